// File: rtl/program_loader.sv
// program_loader -- receives a framed program image over a byte stream and
// writes it into instruction memory, then pulses the CPU start input.
//
// Frame: HEADER, LEN_HI, LEN_LO, N x {B0,B1,B2}, CSUM
//   N    = {LEN_HI[1:0], LEN_LO} + 1   (1..1024 words)
//   word = {B0[1:0], B1, B2}           (18 bits)
//   CSUM = XOR of every byte between HEADER and CSUM
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous reset, active low
//   rx_valid   rx_data holds a byte
//   rx_data    incoming byte
//   rx_ready   loader can accept a byte (low only in WRITE and in reset)
//   mem_we     one-cycle instruction-memory write strobe
//   mem_waddr  instruction-memory word address
//   mem_wdata  assembled instruction word
//   busy       frame in progress (LEN_HI..CHECK)
//   done       last frame loaded with good checksum (sticky)
//   error      last frame rejected (sticky)
//   cpu_start  one-cycle pulse on entry to DONE
module program_loader #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [9:0]  mem_waddr,
    output logic [17:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_start
);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  len_q, len_d;     // N-1
    logic [9:0]  addr_q, addr_d;   // doubles as the word counter
    logic [17:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic        start_q, start_d;

    logic accept;
    logic last_word;

    assign accept    = rx_valid && rx_ready;
    assign last_word = (addr_q == len_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        word_d  = word_q;
        csum_d  = csum_q;
        start_d = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                // Anything but HEADER is swallowed; done/error stay put.
                if (accept && rx_data == HEADER) state_d = LEN_HI;
            end
            LEN_HI: if (accept) begin
                if (rx_data[7:2] != 6'd0) begin
                    state_d = ERROR;
                end else begin
                    len_d[9:8] = rx_data[1:0];
                    csum_d     = rx_data;  // checksum restarts with LEN_HI
                    state_d    = LEN_LO;
                end
            end
            LEN_LO: if (accept) begin
                len_d[7:0] = rx_data;
                csum_d     = csum_q ^ rx_data;
                addr_d     = '0;
                state_d    = B0;
            end
            B0: if (accept) begin
                if (rx_data[7:2] != 6'd0) begin
                    state_d = ERROR;
                end else begin
                    word_d[17:16] = rx_data[1:0];
                    csum_d        = csum_q ^ rx_data;
                    state_d       = B1;
                end
            end
            B1: if (accept) begin
                word_d[15:8] = rx_data;
                csum_d       = csum_q ^ rx_data;
                state_d      = B2;
            end
            B2: if (accept) begin
                word_d[7:0] = rx_data;
                csum_d      = csum_q ^ rx_data;
                state_d     = WRITE;
            end
            WRITE: begin
                // The address is not advanced past the last word, so it
                // never wraps at N=1024 and holds its value between frames.
                if (last_word) begin
                    state_d = CHECK;
                end else begin
                    addr_d  = addr_q + 10'd1;
                    state_d = B0;
                end
            end
            CHECK: if (accept) begin
                if (rx_data == csum_q) begin
                    state_d = DONE;
                    start_d = 1'b1;
                end else begin
                    state_d = ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rx_ready is qualified by reset so it reads 0 while reset is held,
    // yet is already 1 at the first edge after release.
    assign rx_ready  = reset && (state_q != WRITE);
    assign mem_we    = (state_q == WRITE);
    assign mem_waddr = addr_q;
    assign mem_wdata = word_q;
    assign busy      = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                       (state_q == B0)     || (state_q == B1)     ||
                       (state_q == B2)     || (state_q == WRITE)  ||
                       (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);
    assign cpu_start = start_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte stream in, instruction-memory
// writes and status outputs checked against hand-computed values.
module tb_program_loader;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [17:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_start;

    program_loader #(.HEADER(HDR)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
        .cpu_start(cpu_start)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int n_start = 0;
    int n_stall = 0;
    logic [17:0] exp_words [1024];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must hit the next sequential address
    // with the expected word.
    always @(negedge clock) begin
        if (mem_we) begin
            chk("wr_addr", 32'(mem_waddr), 32'(wr_cnt));
            if (wr_cnt < 1024) chk("wr_data", 32'(mem_wdata), 32'(exp_words[wr_cnt]));
            wr_cnt++;
        end
        if (cpu_start) n_start++;
        if (reset && !rx_ready) n_stall++;
    end

    // Present a byte after 'gap' idle cycles and hold it until rx_ready;
    // returns just before the accepting edge.
    task automatic send(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) begin
            @(negedge clock);
            rx_valid = 1'b0;
        end
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        guard = 0;
        while (!rx_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 20) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clock);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input int n, input int gmax);
        logic [9:0] l;
        logic [7:0] cs;
        logic [7:0] b;
        l  = 10'(n - 1);
        send(HDR, $urandom_range(0, gmax));
        b  = {6'd0, l[9:8]};
        cs = b;
        send(b, $urandom_range(0, gmax));
        cs = cs ^ l[7:0];
        send(l[7:0], $urandom_range(0, gmax));
        for (int i = 0; i < n; i++) begin
            b = {6'd0, exp_words[i][17:16]}; cs = cs ^ b; send(b, $urandom_range(0, gmax));
            b = exp_words[i][15:8];          cs = cs ^ b; send(b, $urandom_range(0, gmax));
            b = exp_words[i][7:0];           cs = cs ^ b; send(b, $urandom_range(0, gmax));
        end
        send(cs, $urandom_range(0, gmax));
    endtask

    task automatic new_frame();
        wr_cnt  = 0;
        n_start = 0;
        n_stall = 0;
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_ctl",  32'({rx_ready, mem_we, busy, done, error, cpu_start}), 32'd0);
        chk("rst_addr", 32'(mem_waddr), 32'd0);
        chk("rst_data", 32'(mem_wdata), 32'd0);
        reset = 1'b1;
        #1;
        chk("rdy_after_rst", 32'(rx_ready), 32'd1);

        // Single word 0x12345; XOR of 00,00,01,23,45 is 8'h67.
        new_frame();
        exp_words[0] = 18'h12345;
        send(8'h11, 0);  // stray byte in IDLE is discarded
        send(HDR, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h01, 0); send(8'h23, 0); send(8'h45, 0); send(8'h67, 0);
        idle(4);
        chk("one_status", 32'({done, error, busy}), 32'b100);
        chk("one_writes", 32'(wr_cnt), 32'd1);
        chk("one_start",  32'(n_start), 32'd1);

        // Two words, extreme values.
        new_frame();
        exp_words[0] = 18'h3FFFF;
        exp_words[1] = 18'h00001;
        send_frame(2, 0);
        idle(4);
        chk("two_status", 32'({done, error, busy}), 32'b100);
        chk("two_writes", 32'(wr_cnt), 32'd2);
        chk("two_start",  32'(n_start), 32'd1);

        // Bad checksum: the word is still written, then rejected.
        new_frame();
        exp_words[0] = 18'h12345;
        send(HDR, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h01, 0); send(8'h23, 0); send(8'h45, 0); send(8'h54, 0);
        idle(4);
        chk("csum_status", 32'({done, error, busy}), 32'b010);
        chk("csum_writes", 32'(wr_cnt), 32'd1);
        chk("csum_start",  32'(n_start), 32'd0);

        // Illegal B0 byte.
        new_frame();
        send(HDR, 0); send(8'h00, 0); send(8'h00, 0); send(8'h04, 0);
        idle(4);
        chk("b0_status", 32'({done, error, busy}), 32'b010);
        chk("b0_writes", 32'(wr_cnt), 32'd0);
        chk("b0_start",  32'(n_start), 32'd0);

        // Illegal LEN_HI byte.
        new_frame();
        send(HDR, 0); send(8'h04, 0);
        idle(4);
        chk("lenhi_status", 32'({done, error, busy}), 32'b010);
        chk("lenhi_start",  32'(n_start), 32'd0);

        // Full 1024-word image with random valid gaps.
        new_frame();
        for (int i = 0; i < 1024; i++) exp_words[i] = 18'($urandom);
        send_frame(1024, 2);
        idle(4);
        chk("big_status", 32'({done, error, busy}), 32'b100);
        chk("big_writes", 32'(wr_cnt), 32'd1024);
        chk("big_start",  32'(n_start), 32'd1);

        // Back-to-back bytes with HEADER values embedded in the data:
        // rx_ready must drop exactly once per word.
        new_frame();
        exp_words[0] = 18'h0A5A5;
        exp_words[1] = 18'h2A5FF;
        exp_words[2] = 18'h10000;
        send_frame(3, 0);
        idle(4);
        chk("cont_status", 32'({done, error, busy}), 32'b100);
        chk("cont_writes", 32'(wr_cnt), 32'd3);
        chk("cont_stalls", 32'(n_stall), 32'd3);

        // Reset in B1 aborts the frame; the next frame starts at address 0.
        new_frame();
        send(HDR, 0); send(8'h00, 0); send(8'h01, 0); send(8'h02, 0);
        idle(1);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ctl",  32'({rx_ready, mem_we, busy, done, error, cpu_start}), 32'd0);
        chk("mid_rst_data", 32'(mem_wdata), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle(2);
        chk("mid_no_start", 32'(n_start), 32'd0);
        new_frame();
        exp_words[0] = 18'h2BEEF;
        exp_words[1] = 18'h1C0DE;
        send_frame(2, 1);
        idle(4);
        chk("after_status", 32'({done, error, busy}), 32'b100);
        chk("after_writes", 32'(wr_cnt), 32'd2);
        chk("after_start",  32'(n_start), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
